imem_word_reader: RTL

- Hardware reader for the CPU's byte-wide instruction/data memory; the counterpart of the word-to-byte program loader.
- On request, it reads N consecutive 32-bit words from a base byte address and assembles each word from 4 big-endian byte reads (byte at addr = bits 31:24).
- It streams each word out on a valid/ready port, for memory dumps and self-check after a program run.

---
 rtl/imem_word_reader_pkg.sv | 21 ++
 rtl/imem_word_reader_if.sv | 30 +++
 rtl/imem_word_reader_byte_word_assembler.sv | 31 +++
 rtl/imem_word_reader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/imem_word_reader_pkg.sv
// rtl/imem_word_reader_pkg.sv - shared state encoding and byte-lane mapping for the word reader
package imem_word_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SEND  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Big-endian lane placement; the program loader uses the same constants,
    // so byte at the lowest address always lands in the top byte of the word.
    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

endpackage

// File: rtl/imem_word_reader_if.sv
// rtl/imem_word_reader_if.sv - memory read port and word output stream bundle
//   master: the reader (drives strobe/address, word stream)
//   slave : memory + consumer (drives read data and out_ready)
interface imem_word_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic [CNT_WIDTH-1:0]  out_index;
    logic                  out_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/imem_word_reader_byte_word_assembler.sv
// rtl/imem_word_reader_byte_word_assembler.sv - places captured bytes into big-endian lanes of a word
//   clk, reset : clock, async active-high clear
//   cap_en     : capture rdata this cycle
//   cap_lane   : lane index 0..3 (0 = bits 31:24)
//   rdata      : byte from memory
//   word       : assembled 32-bit word
module byte_word_assembler
    import imem_word_reader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic [1:0]  cap_lane,
    input  logic [7:0]  rdata,
    output logic [31:0] word
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= 32'h0;
        end else if (cap_en) begin
            case (cap_lane)
                2'd0:    word[LANE0_LSB +: 8] <= rdata;
                2'd1:    word[LANE1_LSB +: 8] <= rdata;
                2'd2:    word[LANE2_LSB +: 8] <= rdata;
                default: word[LANE3_LSB +: 8] <= rdata;
            endcase
        end
    end

endmodule

// File: rtl/imem_word_reader.sv
// rtl/imem_word_reader.sv - reads N big-endian 32-bit words from byte-wide memory and streams them out
//   clk, reset              : clock, async active-high reset
//   start/base_addr/word_count : request, sampled only when idle
//   bus (master)            : mem_rd_en/mem_addr/mem_rdata byte port, out_* word stream
//   busy, done, err         : status; done/err are single-cycle pulses
module imem_word_reader
    import imem_word_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    imem_word_reader_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  index_q;
    logic [1:0]            rd_lane;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  valid_q;
    logic                  last_q;
    // Memory returns data one cycle after the strobe, so capture trails the
    // strobe by one cycle carrying the lane it was issued for.
    logic                  cap_en;
    logic [1:0]            cap_lane;
    logic [31:0]           word;

    byte_word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .cap_lane (cap_lane),
        .rdata    (bus.mem_rdata),
        .word     (word)
    );

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = word;
    assign bus.out_index = index_q;
    assign bus.out_last  = last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            word_addr <= '0;
            count_q   <= '0;
            index_q   <= '0;
            rd_lane   <= 2'd0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            cap_en    <= 1'b0;
            cap_lane  <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cap_en   <= rd_en_q;
            cap_lane <= rd_lane;
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (base_addr[1:0] != 2'b00) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (word_count == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_READ;
                            word_addr <= base_addr;
                            count_q   <= word_count;
                            index_q   <= '0;
                            rd_lane   <= 2'd0;
                            rd_en_q   <= 1'b1;
                            addr_q    <= base_addr;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_lane == LAST_LANE) begin
                        rd_en_q <= 1'b0;
                        state   <= ST_DRAIN;
                    end else begin
                        rd_lane <= rd_lane + 2'd1;
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Lane 3 lands in the assembler on this same edge.
                    valid_q <= 1'b1;
                    last_q  <= (index_q == count_q - CNT_WIDTH'(1));
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            word_addr <= word_addr + ADDR_WIDTH'(BYTES_PER_WORD);
                            addr_q    <= word_addr + ADDR_WIDTH'(BYTES_PER_WORD);
                            index_q   <= index_q + CNT_WIDTH'(1);
                            rd_lane   <= 2'd0;
                            rd_en_q   <= 1'b1;
                            state     <= ST_READ;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
